// File: rtl/pattern_producer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_producer_pkg
//  Purpose  : Shared encodings for the pattern producer: data mode codes and
//             the two-state control FSM.
//  Revision : 1.0  initial release
// ============================================================================
package pattern_producer_pkg;

    // Data pattern modes as presented on the mode input
    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_DEC   = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    // Control FSM: waiting for start, or streaming beats
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : pattern_producer_pkg
`default_nettype wire

// File: rtl/pattern_producer_next.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_producer_next
//  Purpose  : Combinational successor of the current data word for the
//             selected pattern mode (increment, decrement, Galois LFSR, const).
//  Revision : 1.0  initial release
// ============================================================================
module pattern_producer_next
    import pattern_producer_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] step,
    output logic [DATA_W-1:0] next_data
);

    // Select the next word; arithmetic wraps modulo 2^DATA_W by width
    always_comb begin
        next_data = data;
        case (mode)
            MODE_INC:   next_data = data + step;
            MODE_DEC:   next_data = data - step;
            MODE_LFSR:  next_data = data[0] ? ((data >> 1) ^ LFSR_TAPS) : (data >> 1);
            MODE_CONST: next_data = data;
            default:    next_data = data;
        endcase
    end

endmodule : pattern_producer_next
`default_nettype wire

// File: rtl/pattern_producer.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_producer
//  Purpose  : Test-data source emitting a finite or free-running burst of
//             pattern words under a valid/ready handshake, with last/done.
//  Revision : 1.0  initial release
// ============================================================================
module pattern_producer
    import pattern_producer_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                COUNT_W   = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic               pattern_producer_iclk,
    input  logic               pattern_producer_irst_n,
    input  logic               pattern_producer_start,
    input  logic               pattern_producer_abort,
    input  logic [1:0]         pattern_producer_mode,
    input  logic [DATA_W-1:0]  pattern_producer_seed,
    input  logic [DATA_W-1:0]  pattern_producer_step,
    input  logic [COUNT_W-1:0] pattern_producer_burst_len,
    input  logic               pattern_producer_ready,
    output logic [DATA_W-1:0]  pattern_producer_data,
    output logic               pattern_producer_valid,
    output logic               pattern_producer_last,
    output logic               pattern_producer_done,
    output logic               pattern_producer_busy
);

    state_t             state;
    state_t             state_nxt;

    logic [1:0]         mode_r;
    logic [DATA_W-1:0]  step_r;
    logic [COUNT_W-1:0] len_r;
    logic [COUNT_W-1:0] cnt;
    logic [DATA_W-1:0]  data_r;
    logic               done_r;

    logic [DATA_W-1:0]  next_data;
    logic [DATA_W-1:0]  seed_eff;
    logic               in_run;
    logic               accept;
    logic               is_last;

    logic               load;
    logic               advance;
    logic               finish;
    logic               stop;

    // valid and busy are both exactly "in RUN"; they drop together on finish/abort
    assign in_run  = (state == ST_RUN);
    assign accept  = in_run & pattern_producer_ready;
    assign is_last = in_run & (len_r != '0) & (cnt == (len_r - COUNT_W'(1)));

    // An all-zero LFSR never leaves zero, so a zero seed is replaced by 1
    assign seed_eff = ((pattern_producer_mode == MODE_LFSR) && (pattern_producer_seed == '0))
                    ? DATA_W'(1) : pattern_producer_seed;

    pattern_producer_next #(
        .DATA_W    (DATA_W),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_next (
        .mode      (mode_r),
        .data      (data_r),
        .step      (step_r),
        .next_data (next_data)
    );

    // State register
    always_ff @(posedge pattern_producer_iclk or negedge pattern_producer_irst_n) begin
        if (!pattern_producer_irst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control; abort has priority over a pending accept
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        stop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pattern_producer_start) begin
                    state_nxt = ST_RUN;
                    load      = 1'b1;
                end
            end
            ST_RUN: begin
                if (pattern_producer_abort) begin
                    state_nxt = ST_IDLE;
                    stop      = 1'b1;
                end else if (accept) begin
                    advance = 1'b1;
                    if (is_last) begin
                        state_nxt = ST_IDLE;
                        finish    = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Config latches, beat counter, data word and done pulse
    always_ff @(posedge pattern_producer_iclk or negedge pattern_producer_irst_n) begin
        if (!pattern_producer_irst_n) begin
            mode_r <= MODE_INC;
            step_r <= '0;
            len_r  <= '0;
            cnt    <= '0;
            data_r <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= finish;
            if (load) begin
                mode_r <= pattern_producer_mode;
                step_r <= pattern_producer_step;
                len_r  <= pattern_producer_burst_len;
                cnt    <= '0;
                data_r <= seed_eff;
            end else if (advance && !finish) begin
                data_r <= next_data;
                cnt    <= cnt + COUNT_W'(1);
            end
        end
    end

    assign pattern_producer_data  = data_r;
    assign pattern_producer_valid = in_run;
    assign pattern_producer_last  = is_last;
    assign pattern_producer_done  = done_r;
    assign pattern_producer_busy  = in_run;

endmodule : pattern_producer
`default_nettype wire

// File: tb/tb_pattern_producer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pattern_producer
//  Purpose  : Directed, table-driven self-checking bench for pattern_producer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pattern_producer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic [7:0] seed;
    logic [7:0] step;
    logic [7:0] burst_len;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       done;
    logic       busy;

    int errors;
    int checks;

    typedef struct packed {
        logic [1:0]      mode;
        logic [7:0]      seed;
        logic [7:0]      step;
        logic [7:0]      len;
        logic [2:0]      nbeats;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t vecs [6];

    pattern_producer #(
        .DATA_W    (8),
        .COUNT_W   (8),
        .LFSR_TAPS (8'hB8)
    ) dut (
        .pattern_producer_iclk      (clk),
        .pattern_producer_irst_n    (rst_n),
        .pattern_producer_start     (start),
        .pattern_producer_abort     (abort),
        .pattern_producer_mode      (mode),
        .pattern_producer_seed      (seed),
        .pattern_producer_step      (step),
        .pattern_producer_burst_len (burst_len),
        .pattern_producer_ready     (ready),
        .pattern_producer_data      (data),
        .pattern_producer_valid     (valid),
        .pattern_producer_last      (last),
        .pattern_producer_done      (done),
        .pattern_producer_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] d, input logic l, input logic dn);
        chk({tag, " data"},  {24'd0, data}, {24'd0, d});
        chk({tag, " valid"}, {31'd0, valid}, 32'd1);
        chk({tag, " busy"},  {31'd0, busy},  32'd1);
        chk({tag, " last"},  {31'd0, last},  {31'd0, l});
        chk({tag, " done"},  {31'd0, done},  {31'd0, dn});
    endtask

    task automatic chk_idle(input string tag, input logic dn);
        chk({tag, " valid"}, {31'd0, valid}, 32'd0);
        chk({tag, " busy"},  {31'd0, busy},  32'd0);
        chk({tag, " last"},  {31'd0, last},  32'd0);
        chk({tag, " done"},  {31'd0, done},  {31'd0, dn});
    endtask

    task automatic begin_burst(input logic [1:0] m, input logic [7:0] s, input logic [7:0] st,
                               input logic [7:0] len);
        mode      = m;
        seed      = s;
        step      = st;
        burst_len = len;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        mode      = 2'd0;
        seed      = 8'h00;
        step      = 8'h00;
        burst_len = 8'h00;
        ready     = 1'b0;

        // Expected sequences (exp[0] is the first beat)
        vecs[0] = '{mode: 2'd0, seed: 8'hFE, step: 8'h01, len: 8'd4, nbeats: 3'd4,
                    exp: {8'h01, 8'h00, 8'hFF, 8'hFE}};
        vecs[1] = '{mode: 2'd2, seed: 8'h00, step: 8'h00, len: 8'd3, nbeats: 3'd3,
                    exp: {8'h00, 8'h5C, 8'hB8, 8'h01}};
        vecs[2] = '{mode: 2'd3, seed: 8'hA5, step: 8'h07, len: 8'd2, nbeats: 3'd2,
                    exp: {8'h00, 8'h00, 8'hA5, 8'hA5}};
        vecs[3] = '{mode: 2'd0, seed: 8'h10, step: 8'h20, len: 8'd1, nbeats: 3'd1,
                    exp: {8'h00, 8'h00, 8'h00, 8'h10}};
        vecs[4] = '{mode: 2'd1, seed: 8'h05, step: 8'h03, len: 8'd3, nbeats: 3'd3,
                    exp: {8'h00, 8'hFF, 8'h02, 8'h05}};
        vecs[5] = '{mode: 2'd2, seed: 8'h01, step: 8'h55, len: 8'd4, nbeats: 3'd4,
                    exp: {8'h2E, 8'h5C, 8'hB8, 8'h01}};

        // Reset state
        #12;
        chk("reset data", {24'd0, data}, 32'd0);
        chk_idle("reset", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_idle("after reset", 1'b0);

        // Table-driven bursts with ready held high
        ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            begin_burst(vecs[v].mode, vecs[v].seed, vecs[v].step, vecs[v].len);
            for (int i = 0; i < int'(vecs[v].nbeats); i++) begin
                chk_beat($sformatf("vec%0d beat%0d", v, i), vecs[v].exp[i],
                         (i == int'(vecs[v].nbeats) - 1), 1'b0);
                tick();
            end
            chk_idle($sformatf("vec%0d end", v), 1'b1);
            tick();
            chk_idle($sformatf("vec%0d after", v), 1'b0);
        end

        // Back-pressure: hold FF for 3 cycles, then complete
        begin_burst(2'd0, 8'hFE, 8'h01, 8'd4);
        chk_beat("stall b0", 8'hFE, 1'b0, 1'b0);
        tick();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_beat($sformatf("stall hold%0d", i), 8'hFF, 1'b0, 1'b0);
            tick();
        end
        chk_beat("stall hold3", 8'hFF, 1'b0, 1'b0);
        ready = 1'b1;
        tick();
        chk_beat("stall b2", 8'h00, 1'b0, 1'b0);
        tick();
        chk_beat("stall b3", 8'h01, 1'b1, 1'b0);
        tick();
        chk_idle("stall end", 1'b1);
        tick();

        // Free-running DEC, then abort
        begin_burst(2'd1, 8'h05, 8'h03, 8'd0);
        chk_beat("free b0", 8'h05, 1'b0, 1'b0);
        tick();
        chk_beat("free b1", 8'h02, 1'b0, 1'b0);
        tick();
        chk_beat("free b2", 8'hFF, 1'b0, 1'b0);
        tick();
        chk_beat("free b3", 8'hFC, 1'b0, 1'b0);
        tick();
        chk_beat("free b4", 8'hF9, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("abort", 1'b0);
        tick();
        chk_idle("abort after", 1'b0);

        // Asynchronous reset in the middle of a burst
        begin_burst(2'd0, 8'hFE, 8'h01, 8'd4);
        tick();
        chk_beat("rst pre", 8'hFF, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst mid data", {24'd0, data}, 32'd0);
        chk_idle("rst mid", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_idle("rst released", 1'b0);
        tick();
        chk_idle("rst released2", 1'b0);

        // Start during RUN is ignored; start in the done cycle is taken
        ready = 1'b0;
        begin_burst(2'd0, 8'h10, 8'h01, 8'd3);
        chk_beat("ign b0", 8'h10, 1'b0, 1'b0);
        mode  = 2'd3;
        seed  = 8'h80;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_beat("ign held", 8'h10, 1'b0, 1'b0);
        ready = 1'b1;
        tick();
        chk_beat("ign b1", 8'h11, 1'b0, 1'b0);
        tick();
        chk_beat("ign b2", 8'h12, 1'b1, 1'b0);
        tick();
        chk_idle("ign end", 1'b1);
        begin_burst(2'd3, 8'h40, 8'h00, 8'd1);
        chk_beat("donestart b0", 8'h40, 1'b1, 1'b0);
        tick();
        chk_idle("donestart end", 1'b1);
        tick();

        // Abort while idle has no effect on a simultaneous start
        abort = 1'b1;
        begin_burst(2'd3, 8'h3C, 8'h00, 8'd1);
        abort = 1'b0;
        chk_beat("idleabort b0", 8'h3C, 1'b1, 1'b0);
        tick();
        chk_idle("idleabort end", 1'b1);
        tick();
        chk_idle("idleabort after", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pattern_producer
`default_nettype wire
